iic_reg_sequencer: RTL and testbench

Table-driven I2C register-write sequencer for the video encoder on the DVI output path. It owns a small register/value table with two pixel-clock profiles and issues each write as byte-level commands to the shared I2C byte master. It retries NACKed transactions and reports Done or Error to the VGA controller's bring-up logic. Pulsing Start reruns the table at any later time, for example after a video mode change that crosses the 65 MHz boundary.

---
 rtl/iic_reg_sequencer_if.sv | 25 ++
 rtl/iic_reg_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_iic_reg_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_reg_sequencer_if.sv
// Byte-level command/response channel between the register sequencer and
// the shared I2C byte master.
interface iic_reg_sequencer_if;
  logic       Cmd_valid;
  logic       Cmd_ready;
  logic       Cmd_start;
  logic       Cmd_stop;
  logic       Cmd_read;
  logic [7:0] Cmd_byte;
  logic       Rsp_valid;
  logic       Rsp_ack;
  logic [7:0] Rsp_data;

  // Sequencer side: issues commands, consumes responses.
  modport master (
    output Cmd_valid, Cmd_start, Cmd_stop, Cmd_read, Cmd_byte,
    input  Cmd_ready, Rsp_valid, Rsp_ack, Rsp_data
  );

  // Byte master side.
  modport slave (
    input  Cmd_valid, Cmd_start, Cmd_stop, Cmd_read, Cmd_byte,
    output Cmd_ready, Rsp_valid, Rsp_ack, Rsp_data
  );
endinterface

// File: rtl/iic_reg_sequencer.sv
// Table-driven I2C register-write sequencer for the DVI video encoder.
// Walks a 5-entry register/value table (fast or slow pixel-clock profile),
// issuing each write as ADDR / REG / DATA byte commands, retrying NACKed
// entries after an idle gap, and reporting Done or Error.
// Optional: define IIC_SEQ_READBACK_EN to verify each write by reading the
// register back (repeated-START read) before moving on.
module iic_reg_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h76,
  parameter int unsigned RETRY_MAX  = 3,
  parameter int unsigned GAP_CYCLES = 3000
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Pixel_clk_greater_than_65Mhz,
  iic_reg_sequencer_if.master       bus,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Error,
  output logic [2:0]                Fail_index
);

  localparam logic [7:0]  ADDR_W    = {SLAVE_ADDR, 1'b0};
`ifdef IIC_SEQ_READBACK_EN
  localparam logic [7:0]  ADDR_R    = {SLAVE_ADDR, 1'b1};
`endif
  localparam logic [2:0]  RETRY_LIM = 3'(RETRY_MAX);
  localparam logic [2:0]  LAST_IDX  = 3'd4;
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ADDR, S_REG, S_DATA, S_GAP, S_NEXT, S_DONE, S_FAIL
`ifdef IIC_SEQ_READBACK_EN
    , S_RB_ADDR, S_RB_REG, S_RB_RADDR, S_RB_READ
`endif
  } state_t;

  function automatic logic [7:0] tbl_reg(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h49;
      3'd1:    return 8'h21;
      3'd2:    return 8'h33;
      3'd3:    return 8'h34;
      3'd4:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] tbl_val(input logic fast, input logic [2:0] i);
    case (i)
      3'd0:    return 8'hC0;
      3'd1:    return 8'h09;
      3'd2:    return fast ? 8'h06 : 8'h08;
      3'd3:    return fast ? 8'h26 : 8'h16;
      3'd4:    return fast ? 8'hA0 : 8'h60;
      default: return 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        profile_q;
  logic [2:0]  idx_q;
  logic [2:0]  retry_q;
  logic        outst_q;     // command accepted, response not yet seen
  logic        fail_pend_q; // current GAP follows a failed attempt
  logic [15:0] gap_q;
  logic        done_q, error_q;
  logic [2:0]  fidx_q;

  logic        cmd_en, c_start, c_stop, c_read;
  logic [7:0]  c_byte;
  logic        rsp_take, rsp_ok, entry_done, entry_fail, last_entry;

  // Command fields decoded from the current command state.
  always_comb begin
    cmd_en  = 1'b0;
    c_start = 1'b0;
    c_stop  = 1'b0;
    c_read  = 1'b0;
    c_byte  = 8'h00;
    case (state_q)
      S_ADDR: begin cmd_en = 1'b1; c_start = 1'b1; c_byte = ADDR_W; end
      S_REG:  begin cmd_en = 1'b1; c_byte = tbl_reg(idx_q); end
      S_DATA: begin cmd_en = 1'b1; c_stop = 1'b1; c_byte = tbl_val(profile_q, idx_q); end
`ifdef IIC_SEQ_READBACK_EN
      S_RB_ADDR:  begin cmd_en = 1'b1; c_start = 1'b1; c_byte = ADDR_W; end
      S_RB_REG:   begin cmd_en = 1'b1; c_byte = tbl_reg(idx_q); end
      S_RB_RADDR: begin cmd_en = 1'b1; c_start = 1'b1; c_byte = ADDR_R; end
      S_RB_READ:  begin cmd_en = 1'b1; c_read = 1'b1; c_stop = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign bus.Cmd_valid = cmd_en & ~outst_q;
  assign bus.Cmd_start = c_start;
  assign bus.Cmd_stop  = c_stop;
  assign bus.Cmd_read  = c_read;
  assign bus.Cmd_byte  = c_byte;

  // Responses only count while a command is outstanding; strays are dropped.
  assign rsp_take   = outst_q & bus.Rsp_valid;
  assign last_entry = (idx_q == LAST_IDX);

`ifdef IIC_SEQ_READBACK_EN
  assign rsp_ok     = (state_q == S_RB_READ) ? (bus.Rsp_data == tbl_val(profile_q, idx_q))
                                             : bus.Rsp_ack;
  assign entry_done = rsp_take & rsp_ok & (state_q == S_RB_READ);
`else
  logic unused_rsp_data;
  assign unused_rsp_data = ^bus.Rsp_data;
  assign rsp_ok     = bus.Rsp_ack;
  assign entry_done = rsp_take & rsp_ok & (state_q == S_DATA);
`endif
  assign entry_fail = rsp_take & ~rsp_ok;

  // State register; reset lands in LOAD so the table runs without a Start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_LOAD;
      S_LOAD: state_d = S_ADDR;
      S_ADDR: if (rsp_take) state_d = rsp_ok ? S_REG  : S_GAP;
      S_REG:  if (rsp_take) state_d = rsp_ok ? S_DATA : S_GAP;
      S_DATA: if (rsp_take) begin
`ifdef IIC_SEQ_READBACK_EN
        state_d = rsp_ok ? S_RB_ADDR : S_GAP;
`else
        state_d = (rsp_ok && last_entry) ? S_DONE : S_GAP;
`endif
      end
`ifdef IIC_SEQ_READBACK_EN
      S_RB_ADDR:  if (rsp_take) state_d = rsp_ok ? S_RB_REG   : S_GAP;
      S_RB_REG:   if (rsp_take) state_d = rsp_ok ? S_RB_RADDR : S_GAP;
      S_RB_RADDR: if (rsp_take) state_d = rsp_ok ? S_RB_READ  : S_GAP;
      S_RB_READ:  if (rsp_take) state_d = (rsp_ok && last_entry) ? S_DONE : S_GAP;
`endif
      // After a failed attempt the gap leads back to ADDR (or FAIL once the
      // retry budget is spent); after a good entry it leads to NEXT.
      S_GAP: if (gap_q == 16'd0) begin
        if (!fail_pend_q)            state_d = S_NEXT;
        else if (retry_q >= RETRY_LIM) state_d = S_FAIL;
        else                         state_d = S_ADDR;
      end
      S_NEXT: state_d = S_ADDR;
      S_DONE: state_d = S_IDLE;
      S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Index, retry, gap counter, handshake tracking and sticky status.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      profile_q   <= 1'b0;
      idx_q       <= 3'd0;
      retry_q     <= 3'd0;
      outst_q     <= 1'b0;
      fail_pend_q <= 1'b0;
      gap_q       <= 16'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      fidx_q      <= 3'd0;
    end else begin
      if (bus.Cmd_valid && bus.Cmd_ready) outst_q <= 1'b1;
      else if (rsp_take)                  outst_q <= 1'b0;

      case (state_q)
        S_IDLE: if (Start) begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          fidx_q  <= 3'd0;
        end
        S_LOAD: begin
          profile_q   <= Pixel_clk_greater_than_65Mhz;
          idx_q       <= 3'd0;
          retry_q     <= 3'd0;
          fail_pend_q <= 1'b0;
        end
        S_GAP: begin
          if (gap_q != 16'd0) gap_q <= gap_q - 16'd1;
          else                fail_pend_q <= 1'b0;
        end
        S_NEXT: idx_q <= idx_q + 3'd1;
        default: ;
      endcase

      if (entry_fail) begin
        retry_q     <= retry_q + 3'd1;
        fail_pend_q <= 1'b1;
      end
      if (entry_done) retry_q <= 3'd0;

      if (state_d == S_GAP && state_q != S_GAP) gap_q <= GAP_LOAD;
      if (state_d == S_DONE) done_q <= 1'b1;
      if (state_d == S_FAIL) begin
        error_q <= 1'b1;
        fidx_q  <= idx_q;
      end
    end
  end

  assign Busy       = (state_q != S_IDLE);
  assign Done       = done_q;
  assign Error      = error_q;
  assign Fail_index = fidx_q;

endmodule

// File: tb/tb_iic_reg_sequencer.sv
// Scoreboard bench for iic_reg_sequencer: expected command streams come from
// a per-attempt model of the table walk; a byte-master model answers with
// scripted NACKs / bad read data; a monitor pops and compares every accepted
// command and checks handshake timing.
module tb_iic_reg_sequencer;
  localparam int G    = 16;
  localparam int RMAX = 3;
  localparam logic [7:0] AW = 8'hEC;
  localparam logic [7:0] AR = 8'hED;

  typedef struct packed {
    logic       s;
    logic       p;
    logic       r;
    logic [7:0] b;
  } cmd_t;

  logic Clk = 1'b0;
  logic Reset, Start, Sel;
  logic Busy, Done, Error;
  logic [2:0] Fail_index;

  iic_reg_sequencer_if bus();

  iic_reg_sequencer #(.SLAVE_ADDR(7'h76), .RETRY_MAX(RMAX), .GAP_CYCLES(G)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Pixel_clk_greater_than_65Mhz(Sel),
    .bus(bus), .Busy(Busy), .Done(Done), .Error(Error), .Fail_index(Fail_index)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] t_reg(input int i);
    case (i)
      0: return 8'h49; 1: return 8'h21; 2: return 8'h33; 3: return 8'h34; default: return 8'h36;
    endcase
  endfunction

  function automatic logic [7:0] t_val(input bit fast, input int i);
    case (i)
      0: return 8'hC0;
      1: return 8'h09;
      2: return fast ? 8'h06 : 8'h08;
      3: return fast ? 8'h26 : 8'h16;
      default: return fast ? 8'hA0 : 8'h60;
    endcase
  endfunction

  function automatic cmd_t mk(input bit s, input bit p, input bit r, input logic [7:0] b);
    cmd_t c;
    c.s = s; c.p = p; c.r = r; c.b = b;
    return c;
  endfunction

  // Scoreboard and expected end-of-run status.
  cmd_t exp_q[$];
  bit   exp_done, exp_err;
  int   exp_fidx;

  // Byte-master model knobs and state.
  logic [7:0] nk_reg, rb_reg, ptr;
  int   nk_pos, nk_left, rb_left;
  int   m_hold_at = -1, m_hold_len = 0, m_cmd_cnt = 0;
  bit   m_spur_req = 0, m_spur = 0;
  logic [7:0] mem [256];

  // Expected stream: each attempt of each entry, consuming scripted faults
  // in the same order the slave sees them.
  task automatic plan_run(input bit sel, input logic [7:0] nreg, input int npos, input int nn,
                          input logic [7:0] rreg, input int rn);
    int fails, nl, rl;
    bit bad;
    nk_reg = nreg; nk_pos = npos; nk_left = nn;
    rb_reg = rreg; rb_left = rn;
    m_cmd_cnt = 0;
    nl = nn; rl = rn;
    exp_done = 1; exp_err = 0; exp_fidx = 0;
    for (int i = 0; i < 5 && !exp_err; i++) begin
      fails = 0;
      while (1) begin
        bad = 0;
        exp_q.push_back(mk(1, 0, 0, AW));
        exp_q.push_back(mk(0, 0, 0, t_reg(i)));
        if (t_reg(i) == nreg && npos == 1 && nl > 0) begin nl--; bad = 1; end
        else begin
          exp_q.push_back(mk(0, 1, 0, t_val(sel, i)));
          if (t_reg(i) == nreg && npos == 2 && nl > 0) begin nl--; bad = 1; end
`ifdef IIC_SEQ_READBACK_EN
          else begin
            exp_q.push_back(mk(1, 0, 0, AW));
            exp_q.push_back(mk(0, 0, 0, t_reg(i)));
            exp_q.push_back(mk(1, 0, 0, AR));
            exp_q.push_back(mk(0, 1, 1, 8'h00));
            if (t_reg(i) == rreg && rl > 0) begin rl--; bad = 1; end
          end
`endif
        end
        if (!bad) break;
        fails++;
        if (fails >= RMAX) begin exp_done = 0; exp_err = 1; exp_fidx = i; break; end
      end
    end
  endtask

  // Byte master: random ready delay and response latency, scripted faults.
  initial begin
    int ph, wcnt, lat, tpos;
    logic cs, cr, r_ack;
    logic [7:0] cb, r_data;
    ph = 0; wcnt = -1; lat = 0; tpos = 0; ptr = 8'h00;
    cs = 0; cr = 0; cb = 0; r_ack = 0; r_data = 0;
    bus.Cmd_ready = 0; bus.Rsp_valid = 0; bus.Rsp_ack = 0; bus.Rsp_data = 0;
    forever begin
      @(negedge Clk);
      bus.Cmd_ready = 0; bus.Rsp_valid = 0; bus.Rsp_ack = 0; bus.Rsp_data = 0; m_spur = 0;
      if (Reset === 1'b1) begin ph = 0; wcnt = -1; end
      else case (ph)
        0: if (bus.Cmd_valid) begin
             if (wcnt < 0) wcnt = (m_cmd_cnt == m_hold_at) ? m_hold_len : int'($urandom_range(0, 2));
             if (wcnt == 0) begin
               bus.Cmd_ready = 1; cs = bus.Cmd_start; cr = bus.Cmd_read; cb = bus.Cmd_byte;
               ph = 1; wcnt = -1; m_cmd_cnt++;
             end else wcnt--;
           end else if (m_spur_req) begin
             m_spur_req = 0; m_spur = 1; bus.Rsp_valid = 1; bus.Rsp_ack = 0;
           end
        1: begin
             r_ack = 1; r_data = 8'h00;
             if (cs) tpos = 0;
             else if (cr) begin
               r_data = mem[ptr];
               if (ptr == rb_reg && rb_left > 0) begin rb_left--; r_data = 8'h00; end
             end else begin
               tpos++;
               if (tpos == 1) begin
                 ptr = cb;
                 if (cb == nk_reg && nk_pos == 1 && nk_left > 0) begin nk_left--; r_ack = 0; end
               end else if (ptr == nk_reg && nk_pos == 2 && nk_left > 0) begin
                 nk_left--; r_ack = 0;
               end else mem[ptr] = cb;
             end
             lat = $urandom_range(0, 3);
             ph = 2;
           end
        default: if (lat > 0) lat--;
                 else begin
                   bus.Rsp_valid = 1; bus.Rsp_ack = r_ack; bus.Rsp_data = r_data; ph = 0;
                 end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted command, checks field
  // stability while stalled, valid drop after accept, and retry gap length.
  initial begin
    int cyc, nack_cyc;
    bit pv_valid, pv_wait, pv_hs, nack_pend;
    cmd_t cur, pv_cmd, e, a;
    cyc = 0; nack_cyc = 0; pv_valid = 0; pv_wait = 0; pv_hs = 0; nack_pend = 0; pv_cmd = '0;
    forever begin
      @(negedge Clk); #1;
      cyc++;
      if (Reset !== 1'b0) begin
        pv_valid = 0; pv_wait = 0; pv_hs = 0; nack_pend = 0;
        continue;
      end
      cur = {bus.Cmd_start, bus.Cmd_stop, bus.Cmd_read, bus.Cmd_byte};
      if (pv_hs) chk("valid_drop_after_accept", bus.Cmd_valid, 0);
      if (pv_wait) begin
        chk("stall_valid_held", bus.Cmd_valid, 1);
        chk("stall_fields_stable", cur, pv_cmd);
      end
      if (bus.Cmd_valid && !pv_valid && cur.s && cur.b == AW && nack_pend) begin
        chk("retry_gap_cycles", cyc - nack_cyc - 1, G);
        nack_pend = 0;
      end
      if (bus.Cmd_valid && bus.Cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd: got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          a = cur;
          if (a.r) a.b = 8'h00;
          chk("cmd", a, e);
        end
      end
      if (bus.Rsp_valid && !bus.Rsp_ack && !m_spur) begin nack_pend = 1; nack_cyc = cyc; end
      if (!Busy) nack_pend = 0;
      pv_valid = bus.Cmd_valid;
      pv_wait  = bus.Cmd_valid && !bus.Cmd_ready;
      pv_hs    = bus.Cmd_valid && bus.Cmd_ready;
      pv_cmd   = cur;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy !== 1'b0 && n < 4000) begin @(negedge Clk); #1; n++; end
    chk("run_finishes_idle", Busy, 0);
  endtask

  task automatic check_end(input string name);
    chk({name, "_done"}, Done, exp_done);
    chk({name, "_error"}, Error, exp_err);
    if (exp_err) chk({name, "_fail_index"}, Fail_index, exp_fidx);
    chk({name, "_all_cmds_seen"}, exp_q.size(), 0);
  endtask

  // Start pulse at edge N: LOAD in N+1, ADDR command presented in N+2.
  task automatic start_run();
    @(negedge Clk); Start = 1;
    @(negedge Clk); Start = 0; #1;
    chk("load_busy", Busy, 1);
    chk("load_valid", bus.Cmd_valid, 0);
    chk("load_done_cleared", Done, 0);
    chk("load_error_cleared", Error, 0);
    @(negedge Clk); #1;
    chk("addr_valid", bus.Cmd_valid, 1);
    chk("addr_byte", bus.Cmd_byte, AW);
    chk("addr_start", bus.Cmd_start, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, f, k;
    Reset = 0; Start = 0; Sel = 1;
    #1 Reset = 1;
    #2;
    chk("rst_cmd_valid", bus.Cmd_valid, 0);
    chk("rst_cmd_start", bus.Cmd_start, 0);
    chk("rst_cmd_stop", bus.Cmd_stop, 0);
    chk("rst_cmd_read", bus.Cmd_read, 0);
    chk("rst_cmd_byte", bus.Cmd_byte, 8'h00);
    chk("rst_busy", Busy, 1);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_fail_index", Fail_index, 0);

    // Run 0: automatic after reset, fast profile, always ACK.
    plan_run(1, 8'h00, 0, 0, 8'h00, 0);
    @(negedge Clk); @(negedge Clk); Reset = 0;
    wait_idle();
    check_end("run0_fast");

    // Stray response in IDLE must not wake the block.
    m_spur_req = 1;
    repeat (4) @(negedge Clk);
    #1;
    chk("stray_rsp_idle_busy", Busy, 0);
    chk("stray_rsp_idle_done", Done, 1);

    // Run 1: slow profile via Start.
    Sel = 0;
    plan_run(0, 8'h00, 0, 0, 8'h00, 0);
    start_run();
    wait_idle();
    check_end("run1_slow");

    // Run 2: REG of index 2 NACKed twice, then recovers.
    Sel = 1'($urandom_range(0, 1));
    plan_run(Sel, 8'h33, 1, 2, 8'h00, 0);
    start_run();
    wait_idle();
    check_end("run2_retry");

    // Run 3: index 3 always NACKs; profile flips mid-run with no effect.
    Sel = 1;
    plan_run(1, 8'h34, $urandom_range(1, 2), 7, 8'h00, 0);
    start_run();
    repeat (20) @(negedge Clk);
    Sel = 0;
    wait_idle();
    check_end("run3_fault");

    // Run 4: 50-cycle ready stall on the fifth command, Start pulsed meanwhile.
    Sel = 1'($urandom_range(0, 1));
    plan_run(Sel, 8'h00, 0, 0, 8'h00, 0);
    m_hold_at = 4; m_hold_len = 50;
    start_run();
    n = 0;
    while (!(m_cmd_cnt == 4 && bus.Cmd_valid) && n < 500) begin @(negedge Clk); #1; n++; end
    chk("stall_reached", n < 500, 1);
    repeat (10) @(negedge Clk);
    Start = 1; Sel = ~Sel;
    @(negedge Clk); Start = 0;
    wait_idle();
    check_end("run4_stall");
    m_hold_at = -1;

    // Run 5: reset during a DATA command, then restart from index 0.
    Sel = 1;
    plan_run(1, 8'h00, 0, 0, 8'h00, 0);
    start_run();
    n = 0;
    while (!(bus.Cmd_valid && bus.Cmd_stop && !bus.Cmd_read && m_cmd_cnt >= 5) && n < 500) begin
      @(negedge Clk); #1; n++;
    end
    chk("data_cmd_reached", n < 500, 1);
    #2 Reset = 1;
    #1;
    chk("async_rst_valid", bus.Cmd_valid, 0);
    chk("async_rst_busy", Busy, 1);
    exp_q.delete();
    Sel = 0;
    plan_run(0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge Clk); @(negedge Clk); Reset = 0;
    wait_idle();
    check_end("run5_after_reset");

    // Randomised runs: profile, fault position/count, stray responses.
    for (int r = 0; r < 4; r++) begin
      s = $urandom_range(0, 1);
      f = $urandom_range(0, 2);
      k = $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      Sel = 1'(s);
      m_spur_req = 1'($urandom_range(0, 1));
`ifdef IIC_SEQ_READBACK_EN
      if (f == 2) plan_run(1'(s), 8'h00, 0, 0, t_reg(k), n);
      else
`endif
      if (f == 0) plan_run(1'(s), 8'h00, 0, 0, 8'h00, 0);
      else        plan_run(1'(s), t_reg(k), $urandom_range(1, 2), n, 8'h00, 0);
      start_run();
      wait_idle();
      check_end("rand_run");
    end

`ifdef IIC_SEQ_READBACK_EN
    // Read-back of index 0 returns 00 once: one retry, then completion.
    Sel = 1;
    plan_run(1, 8'h00, 0, 0, 8'h49, 1);
    start_run();
    wait_idle();
    check_end("readback_retry");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
